tmr_mem_scrub_ctrl: RTL and testbench
=====================================

// Module: tmr_mem_scrub_ctrl
// PURPOSE
//  Initiator-side controller for the 256x8 TMR SRAM `top` (clk/rst/enable/we/addr/data_in/data_out).
//  Serializes host read/write requests over a valid/ready handshake and, when idle, runs a background
//  scrubber: read one address (voted data), write it back, re-syncing all three copies and clearing
//  single-copy upsets before a second upset makes them uncorrectable.
// PARAMETERS
//  ADDR_W     8    address width; scrub walks 0..2**ADDR_W-1
//  DATA_W     8    data width
//  RD_LAT     1    cycles from read-issue cycle to valid mem_rdata (>=1)
//  SCRUB_GAP  16   idle cycles between scrub steps (0 = back-to-back)
// PORTS
//  clk          in   1       clock, all logic on posedge
//  rst          in   1       synchronous, active-high reset
//  req_valid    in   1       host request valid
//  req_ready    out  1       controller can accept request
//  req_we       in   1       1=write, 0=read
//  req_addr     in   ADDR_W  request address
//  req_wdata    in   DATA_W  write data
//  rsp_valid    out  1       1-cycle pulse, rsp_rdata valid (reads only)
//  rsp_rdata    out  DATA_W  read data, held until next rsp_valid
//  scrub_en     in   1       enable background scrubbing
//  scrub_busy   out  1       scrub step (read+writeback) in progress
//  scrub_done   out  1       1-cycle pulse when scrub address wraps DEPTH-1 -> 0
//  scrub_passes out  16      completed passes, saturates at 16'hFFFF
//  mem_enable   out  1       to top.enable
//  mem_we       out  1       to top.we
//  mem_addr     out  ADDR_W  to top.addr
//  mem_wdata    out  DATA_W  to top.data_in
//  mem_rdata    in   DATA_W  from top.data_out (already voted)
// BEHAVIOUR
//  - Reset: state IDLE; req_ready=1 from first cycle after reset; rsp_valid, rsp_rdata, mem_enable, mem_we,
//    mem_addr, mem_wdata, scrub_busy, scrub_done, scrub_passes, scrub addr, gap counter all 0.
//  - All mem_* and rsp_* outputs registered. req_ready=1 only in IDLE (and not on reset cycle).
//  - States: IDLE, H_WR, H_RD, H_RWAIT, S_RD, S_RWAIT, S_WB.
//  - IDLE: req_valid&req_ready -> H_WR or H_RD, capturing addr/data. Else if scrub_en and gap counter==0
//    -> S_RD. Host request always wins over starting a scrub step in the same cycle.
//  - H_WR: one cycle mem_enable=1, mem_we=1, mem_addr/mem_wdata=captured -> IDLE.
//  - H_RD: one cycle mem_enable=1, mem_we=0 (issue cycle t) -> H_RWAIT; mem_rdata sampled at end of
//    cycle t+RD_LAT; rsp_valid=1 in cycle t+RD_LAT+1 -> IDLE. Accept-to-rsp_valid = RD_LAT+2 cycles.
//  - mem_enable=0 in every cycle except issue/write cycles; mem_we=0 whenever mem_enable=0.
//  - S_RD: issue read at scrub addr (scrub_busy=1) -> S_RWAIT (RD_LAT cycles, capture) -> S_WB: write
//    captured value back to same addr -> IDLE; scrub addr +1 mod 2**ADDR_W; gap counter loads SCRUB_GAP.
//  - Scrub step is atomic: host requests stall (req_ready=0) for at most RD_LAT+2 cycles; no rsp_valid
//    is produced by scrub reads.
//  - Gap counter decrements by 1 per IDLE cycle while >0, including cycles serving host requests; held at 0.
//  - Wrap: writeback at addr 2**ADDR_W-1 -> scrub_done=1 next cycle, scrub_passes+1 (saturating).
//  - scrub_en falling mid-step: current step completes; scrub addr retained; resume from it when re-enabled.
//  - req_valid held while req_ready=0: request is not consumed; inputs sampled only on accept.
//  - rst during any state: next cycle IDLE with reset values; in-flight read gives no rsp_valid, partial
//    scrub step abandoned (no writeback).
// TESTING
//  1 scrub_en=0; write 10<-2C, 20<-3C, 30<-A5; read 10,20,30 -> rsp_rdata 2C,3C,A5, each RD_LAT+2 after accept.
//  2 Back-to-back requests, req_valid held high -> one accept every 2 (write) / RD_LAT+2 (read) cycles,
//    mem_enable never high two consecutive cycles.
//  3 Write 20<-3C; force one copy to FF, release; scrub_en=1 SCRUB_GAP=0 for one full pass ->
//    all three copies at addr 20 read 3C directly; host read 20 -> 3C.
//  4 Host req_valid raised in S_RD cycle -> req_ready=0 until step ends, accepted within RD_LAT+3 cycles.
//  5 SCRUB_GAP=0, run 2 passes -> scrub_done pulses exactly twice, scrub_passes=2, data unchanged everywhere.
//  6 rst asserted cycle after read accept -> no rsp_valid, all outputs 0, req_ready=1 one cycle after rst drops.

Source files
------------

// File: rtl/tmr_mem_scrub_ctrl.sv
// Host request serializer and background scrubber for a 256x8 TMR SRAM.
// Idle cycles read one word (voted) and write it back to re-sync the copies.
module tmr_mem_scrub_ctrl #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int RD_LAT    = 1,
  parameter int SCRUB_GAP = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  input  logic              scrub_en,
  output logic              scrub_busy,
  output logic              scrub_done,
  output logic [15:0]       scrub_passes,
  output logic              mem_enable,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int GW = (SCRUB_GAP > 0) ? $clog2(SCRUB_GAP + 1) : 1;

  typedef enum logic [2:0] {
    IDLE, H_WR, H_RD, H_RWAIT, S_RD, S_RWAIT, S_WB
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] scrub_addr;
  logic [GW-1:0]     gap;
  logic [CW-1:0]     lat;
  logic              accept;
  logic              in_scrub;

  assign req_ready = (state == IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  assign in_scrub  = (state == S_RD) || (state == S_RWAIT) || (state == S_WB);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      scrub_addr   <= '0;
      gap          <= '0;
      lat          <= '0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      scrub_busy   <= 1'b0;
      scrub_done   <= 1'b0;
      scrub_passes <= '0;
      mem_enable   <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
    end else begin
      mem_enable <= 1'b0;
      mem_we     <= 1'b0;
      rsp_valid  <= 1'b0;
      scrub_done <= 1'b0;
      if (gap != '0 && !in_scrub) gap <= gap - 1'b1;
      unique case (state)
        IDLE: begin
          // host wins over a scrub step starting in the same cycle
          if (accept) begin
            mem_enable <= 1'b1;
            mem_we     <= req_we;
            mem_addr   <= req_addr;
            if (req_we) mem_wdata <= req_wdata;
            state <= req_we ? H_WR : H_RD;
          end else if (scrub_en && gap == '0) begin
            mem_enable <= 1'b1;
            mem_addr   <= scrub_addr;
            scrub_busy <= 1'b1;
            state      <= S_RD;
          end
        end
        H_WR: state <= IDLE;
        H_RD: begin
          lat   <= CW'(RD_LAT - 1);
          state <= H_RWAIT;
        end
        H_RWAIT: begin
          if (lat == '0) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= mem_rdata;
            state     <= IDLE;
          end else begin
            lat <= lat - 1'b1;
          end
        end
        S_RD: begin
          lat   <= CW'(RD_LAT - 1);
          state <= S_RWAIT;
        end
        S_RWAIT: begin
          if (lat == '0) begin
            mem_enable <= 1'b1;
            mem_we     <= 1'b1;
            mem_wdata  <= mem_rdata;
            state      <= S_WB;
          end else begin
            lat <= lat - 1'b1;
          end
        end
        S_WB: begin
          scrub_busy <= 1'b0;
          scrub_addr <= scrub_addr + 1'b1;
          gap        <= GW'(SCRUB_GAP);
          if (scrub_addr == '1) begin
            scrub_done <= 1'b1;
            if (scrub_passes != '1) scrub_passes <= scrub_passes + 16'd1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tmr_mem_scrub_ctrl.sv
// Directed bench for tmr_mem_scrub_ctrl against a three-copy voted SRAM model.
// Covers host access timing, scrub repair, host/scrub arbitration and reset.
module tb_tmr_mem_scrub_ctrl;

  localparam int RD_LAT = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [7:0]  req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        scrub_en;
  logic        scrub_busy;
  logic        scrub_done;
  logic [15:0] scrub_passes;
  logic        mem_enable;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  tmr_mem_scrub_ctrl #(
    .ADDR_W(8), .DATA_W(8), .RD_LAT(RD_LAT), .SCRUB_GAP(0)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .scrub_en(scrub_en), .scrub_busy(scrub_busy),
    .scrub_done(scrub_done), .scrub_passes(scrub_passes),
    .mem_enable(mem_enable), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // three-copy memory model with majority vote on read
  logic [7:0] c0 [256];
  logic [7:0] c1 [256];
  logic [7:0] c2 [256];
  bit         init_done;
  logic       inj;
  logic [7:0] inj_addr;

  function automatic logic [7:0] vote(logic [7:0] a, logic [7:0] b,
                                      logic [7:0] c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 256; i++) begin
        c0[i] <= 8'(i * 7 + 3);
        c1[i] <= 8'(i * 7 + 3);
        c2[i] <= 8'(i * 7 + 3);
      end
      init_done <= 1'b1;
    end else begin
      if (mem_enable && mem_we) begin
        c0[mem_addr] <= mem_wdata;
        c1[mem_addr] <= mem_wdata;
        c2[mem_addr] <= mem_wdata;
      end
      if (inj) c1[inj_addr] <= 8'hFF;
    end
    if (mem_enable && !mem_we)
      mem_rdata <= vote(c0[mem_addr], c1[mem_addr], c2[mem_addr]);
  end

  int cyc;
  int rsp_cnt;
  int done_cnt;
  int en_viol;
  logic prev_en;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    rsp_cnt  <= rsp_cnt + int'(rsp_valid);
    done_cnt <= done_cnt + int'(scrub_done);
    if (mem_enable && prev_en) en_viol <= en_viol + 1;
    prev_en <= mem_enable;
  end

  logic [44:0] outv;
  assign outv = {rsp_valid, rsp_rdata, mem_enable, mem_we, mem_addr,
                 mem_wdata, scrub_busy, scrub_done, scrub_passes};

  int n_cmp;
  int n_bad;
  logic [7:0] sh [256];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int k = 0;
    while (!req_ready && k < 50) begin
      tick();
      k++;
    end
    if (!req_ready) chk(tag, 64'(req_ready), 64'd1);
  endtask

  task automatic wait_rsp(input string tag, output int k);
    k = 0;
    while (!rsp_valid && k < 20) begin
      tick();
      k++;
    end
    if (!rsp_valid) chk(tag, 64'(rsp_valid), 64'd1);
  endtask

  task automatic host_wr(input logic [7:0] a, input logic [7:0] d);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = a;
    req_wdata = d;
    wait_ready("wr_ready_timeout");
    tick();
    req_valid = 1'b0;
    sh[a] = d;
  endtask

  task automatic host_rd(input string tag, input logic [7:0] a,
                         input logic [7:0] exp);
    int k;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = a;
    wait_ready("rd_ready_timeout");
    tick();
    req_valid = 1'b0;
    wait_rsp("rsp_timeout", k);
    chk({tag, "_lat"}, 64'(k), 64'(RD_LAT + 1));
    chk({tag, "_data"}, 64'(rsp_rdata), 64'(exp));
  endtask

  initial begin
    int k;
    int a0, a1, a2, a3;
    int errs;
    int rsp0;
    int done0;

    n_cmp = 0;
    n_bad = 0;
    for (int i = 0; i < 256; i++) sh[i] = 8'(i * 7 + 3);
    rst = 1'b1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    scrub_en = 1'b0;
    inj = 1'b0;
    inj_addr = '0;
    repeat (3) tick();
    chk("rst_outputs", 64'(outv), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_ready", 64'(req_ready), 64'd1);

    // 1: basic writes then reads
    host_wr(8'h10, 8'h2C);
    host_wr(8'h20, 8'h3C);
    host_wr(8'h30, 8'hA5);
    host_rd("t1_r10", 8'h10, 8'h2C);
    host_rd("t1_r20", 8'h20, 8'h3C);
    host_rd("t1_r30", 8'h30, 8'hA5);

    // 2: back-to-back with req_valid held high
    req_valid = 1'b1;
    req_we = 1'b1; req_addr = 8'h40; req_wdata = 8'h11;
    wait_ready("t2_to0"); tick(); a0 = cyc;
    req_we = 1'b1; req_addr = 8'h41; req_wdata = 8'h22;
    wait_ready("t2_to1"); tick(); a1 = cyc;
    req_we = 1'b0; req_addr = 8'h40;
    wait_ready("t2_to2"); tick(); a2 = cyc;
    req_we = 1'b0; req_addr = 8'h41;
    wait_ready("t2_to3"); tick(); a3 = cyc;
    req_valid = 1'b0;
    sh[8'h40] = 8'h11;
    sh[8'h41] = 8'h22;
    chk("t2_wr_gap0", 64'(a1 - a0), 64'd2);
    chk("t2_wr_gap1", 64'(a2 - a1), 64'd2);
    chk("t2_rd_gap", 64'(a3 - a2), 64'(RD_LAT + 2));
    wait_rsp("t2_rsp_timeout", k);
    chk("t2_rdata", 64'(rsp_rdata), 64'h22);

    // 3: upset one copy, one full scrub pass repairs it
    inj_addr = 8'h20;
    inj = 1'b1;
    tick();
    inj = 1'b0;
    chk("t3_upset", 64'(c1[8'h20]), 64'hFF);
    scrub_en = 1'b1;
    k = 0;
    while (!scrub_done && k < 1500) begin
      tick();
      k++;
    end
    scrub_en = 1'b0;
    chk("t3_done_seen", 64'(scrub_done), 64'd1);
    chk("t3_passes", 64'(scrub_passes), 64'd1);
    chk("t3_c0", 64'(c0[8'h20]), 64'h3C);
    chk("t3_c1", 64'(c1[8'h20]), 64'h3C);
    chk("t3_c2", 64'(c2[8'h20]), 64'h3C);
    host_rd("t3_r20", 8'h20, 8'h3C);

    // 4: host request arriving during a scrub read stalls until step ends
    scrub_en = 1'b1;
    k = 0;
    while (!(mem_enable && !mem_we && scrub_busy) && k < 20) begin
      tick();
      k++;
    end
    chk("t4_srd_seen", 64'(mem_enable && scrub_busy), 64'd1);
    req_valid = 1'b1;
    req_we = 1'b0;
    req_addr = 8'h30;
    chk("t4_stall", 64'(req_ready), 64'd0);
    k = 0;
    while (!req_ready && k < 20) begin
      tick();
      k++;
    end
    chk("t4_stall_len", 64'(k), 64'(RD_LAT + 2));
    tick();
    req_valid = 1'b0;
    scrub_en = 1'b0;
    chk("t4_host_wins", 64'({scrub_busy, mem_enable, mem_we, mem_addr}),
        64'({1'b0, 1'b1, 1'b0, 8'h30}));
    wait_rsp("t4_rsp_timeout", k);
    chk("t4_lat", 64'(k), 64'(RD_LAT + 1));
    chk("t4_data", 64'(rsp_rdata), 64'hA5);

    // 5: two full passes from reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    done0 = done_cnt;
    scrub_en = 1'b1;
    k = 0;
    while (scrub_passes != 16'd2 && k < 3000) begin
      tick();
      k++;
    end
    scrub_en = 1'b0;
    repeat (5) tick();
    chk("t5_passes", 64'(scrub_passes), 64'd2);
    chk("t5_done_cnt", 64'(done_cnt - done0), 64'd2);
    chk("t5_idle", 64'(scrub_busy), 64'd0);
    errs = 0;
    for (int i = 0; i < 256; i++)
      if (c0[i] !== sh[i] || c1[i] !== sh[i] || c2[i] !== sh[i]) errs++;
    chk("t5_mem_intact", 64'(errs), 64'd0);

    // 6: reset right after a read accept drops the response
    req_valid = 1'b1;
    req_we = 1'b0;
    req_addr = 8'h10;
    wait_ready("t6_ready_timeout");
    tick();
    req_valid = 1'b0;
    rsp0 = rsp_cnt;
    rst = 1'b1;
    tick();
    chk("t6_rst_outputs", 64'(outv), 64'd0);
    chk("t6_rst_ready", 64'(req_ready), 64'd0);
    rst = 1'b0;
    tick();
    chk("t6_ready", 64'(req_ready), 64'd1);
    repeat (4) tick();
    chk("t6_no_rsp", 64'(rsp_cnt - rsp0), 64'd0);

    chk("en_never_consecutive", 64'(en_viol), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
